// File: rtl/avalon_pattern_fill.sv
// Avalon-MM burst writer: fills one frame buffer with a selectable test pattern.
// One 24-bit RGB pixel per data word; bursts of BURST_LEN beats with no idle
// cycle between them. Busy/done status goes to the video output path.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a start request after reset
// S_LOAD  | pattern and colours latched; first beat prepared
// S_WRITE | issuing bursts; counters advance on each accepted beat
// S_DONE  | frame complete; waiting for the next start request
module avalon_pattern_fill #(
  parameter int ADDR_W    = 27,
  parameter int DATA_W    = 32,
  parameter int H_ACTIVE  = 1920,
  parameter int V_ACTIVE  = 1080,
  parameter int BURST_LEN = 8,
  parameter int BASE_ADDR = 0,
  parameter int BC_W      = $clog2(BURST_LEN) + 1
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              iSTART,
  input  logic [2:0]        iMODE,
  input  logic [23:0]       iCOLOR_A,
  input  logic [23:0]       iCOLOR_B,
  input  logic              local_init_done,
  input  logic              avl_waitrequest_n,
  output logic [ADDR_W-1:0] avl_address,
  output logic [DATA_W-1:0] avl_writedata,
  output logic              avl_write,
  output logic              avl_burstbegin,
  output logic [BC_W-1:0]   avl_burstcount,
  output logic              oBUSY,
  output logic              oDONE
);

  // Pixel coordinates are kept 16 bits wide so the checker and ramp patterns
  // can index bits 6 and 7:0 even for tiny frame sizes.
  localparam int XW = 16;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        mode_q, mode_d;
  logic [23:0]       col_a_q, col_a_d;
  logic [23:0]       col_b_q, col_b_d;
  logic [XW-1:0]     x_q, x_d;
  logic [XW-1:0]     y_q, y_d;
  logic [BC_W-1:0]   beat_q, beat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [23:0]       rgb_q, rgb_d;
  logic              write_q, write_d;
  logic              bb_q, bb_d;

  function automatic logic [23:0] pixel(input logic [2:0] mode,
                                        input logic [23:0] ca,
                                        input logic [23:0] cb,
                                        input logic [XW-1:0] x,
                                        input logic [XW-1:0] y);
    case (mode)
      3'd0:    pixel = ca;
      3'd1:    pixel = (x < XW'(H_ACTIVE / 2)) ? ca : cb;
      3'd2:    pixel = (y < XW'(V_ACTIVE / 2)) ? ca : cb;
      3'd3:    pixel = (x[6] ^ y[6]) ? cb : ca;
      3'd4:    pixel = {x[7:0], x[7:0], x[7:0]};
      default: pixel = cb;
    endcase
  endfunction

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      col_a_q <= '0;
      col_b_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      beat_q  <= '0;
      addr_q  <= ADDR_W'(BASE_ADDR);
      rgb_q   <= '0;
      write_q <= 1'b0;
      bb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      col_a_q <= col_a_d;
      col_b_q <= col_b_d;
      x_q     <= x_d;
      y_q     <= y_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      rgb_q   <= rgb_d;
      write_q <= write_d;
      bb_q    <= bb_d;
    end
  end

  // Next-state and next-beat logic; everything holds unless a beat is accepted.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    col_a_d = col_a_q;
    col_b_d = col_b_q;
    x_d     = x_q;
    y_d     = y_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    rgb_d   = rgb_q;
    write_d = write_q;
    bb_d    = bb_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (iSTART && local_init_done) begin
          state_d = S_LOAD;
          mode_d  = iMODE;
          col_a_d = iCOLOR_A;
          col_b_d = iCOLOR_B;
          x_d     = '0;
          y_d     = '0;
          beat_d  = '0;
        end
      end
      S_LOAD: begin
        state_d = S_WRITE;
        write_d = 1'b1;
        bb_d    = 1'b1;
        addr_d  = ADDR_W'(BASE_ADDR);
        rgb_d   = pixel(mode_q, col_a_q, col_b_q, '0, '0);
      end
      S_WRITE: begin
        if (write_q && avl_waitrequest_n) begin
          if (x_q == XW'(H_ACTIVE - 1) && y_q == XW'(V_ACTIVE - 1)) begin
            state_d = S_DONE;
            write_d = 1'b0;
            bb_d    = 1'b0;
            addr_d  = ADDR_W'(BASE_ADDR);
          end else begin
            if (x_q == XW'(H_ACTIVE - 1)) begin
              x_d = '0;
              y_d = y_q + XW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
            rgb_d = pixel(mode_q, col_a_q, col_b_q, x_d, y_d);
            // The address advances only once the whole burst has been accepted.
            if (beat_q == BC_W'(BURST_LEN - 1)) begin
              beat_d = '0;
              addr_d = addr_q + ADDR_W'(BURST_LEN);
              bb_d   = 1'b1;
            end else begin
              beat_d = beat_q + BC_W'(1);
              bb_d   = 1'b0;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign avl_address    = addr_q;
  assign avl_writedata  = DATA_W'(rgb_q);
  assign avl_write      = write_q;
  assign avl_burstbegin = bb_q;
  assign avl_burstcount = BC_W'(BURST_LEN);
  assign oBUSY          = (state_q == S_LOAD) || (state_q == S_WRITE);
  assign oDONE          = (state_q == S_DONE);

endmodule

// File: tb/tb_avalon_pattern_fill.sv
module tb_avalon_pattern_fill;

  localparam int H    = 16;
  localparam int V    = 4;
  localparam int BL   = 4;
  localparam int BASE = 'h100;
  localparam int NB   = H * V;

  logic        iCLK = 1'b0;
  logic        iRST_n;
  logic        iSTART;
  logic [2:0]  iMODE;
  logic [23:0] iCOLOR_A, iCOLOR_B;
  logic        local_init_done;
  logic        avl_waitrequest_n;
  logic [26:0] avl_address;
  logic [31:0] avl_writedata;
  logic        avl_write, avl_burstbegin;
  logic [2:0]  avl_burstcount;
  logic        oBUSY, oDONE;

  avalon_pattern_fill #(
    .ADDR_W(27), .DATA_W(32), .H_ACTIVE(H), .V_ACTIVE(V),
    .BURST_LEN(BL), .BASE_ADDR(BASE)
  ) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iSTART(iSTART), .iMODE(iMODE),
    .iCOLOR_A(iCOLOR_A), .iCOLOR_B(iCOLOR_B), .local_init_done(local_init_done),
    .avl_waitrequest_n(avl_waitrequest_n), .avl_address(avl_address),
    .avl_writedata(avl_writedata), .avl_write(avl_write),
    .avl_burstbegin(avl_burstbegin), .avl_burstcount(avl_burstcount),
    .oBUSY(oBUSY), .oDONE(oDONE)
  );

  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic [26:0] addr;
    logic [31:0] data;
    logic        bb;
  } beat_t;

  typedef struct {
    logic [2:0]  mode;
    logic [23:0] a;
    logic [23:0] b;
    bit          rnd;
    logic [31:0] p5;
    logic [31:0] p60;
  } vec_t;

  beat_t       sbq[$];
  int          errors = 0;
  int          checks = 0;
  int          beat_n = 0;
  int          bursts = 0;
  int          write_cycles = 0;
  logic [31:0] cap[NB];
  bit          rand_wait = 1'b0;
  bit          prev_stall = 1'b0;
  logic [26:0] prev_addr;
  logic [31:0] prev_data;
  logic        prev_bb;
  vec_t        vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] model_px(input logic [2:0] m, input logic [23:0] a,
                                           input logic [23:0] b, input int x, input int y);
    logic [7:0] g;
    g = 8'(x % 256);
    case (m)
      3'd0: return a;
      3'd1: return (x < H / 2) ? a : b;
      3'd2: return (y < V / 2) ? a : b;
      3'd3: return (((x / 64) % 2) != ((y / 64) % 2)) ? b : a;
      3'd4: return {g, g, g};
      default: return b;
    endcase
  endfunction

  task automatic push_frame(input logic [2:0] m, input logic [23:0] a, input logic [23:0] b);
    beat_t e;
    for (int n = 0; n < NB; n++) begin
      e.addr = 27'(BASE + (n / BL) * BL);
      e.data = {8'h00, model_px(m, a, b, n % H, n / H)};
      e.bb   = (n % BL == 0);
      sbq.push_back(e);
    end
  endtask

  // Slave side: random back-pressure when enabled.
  initial begin
    avl_waitrequest_n = 1'b1;
    forever begin
      @(posedge iCLK);
      #1;
      avl_waitrequest_n = rand_wait ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Monitor: scoreboard on accepted beats, stability while stalled.
  initial begin
    beat_t e;
    forever begin
      @(negedge iCLK);
      if (iRST_n) begin
        if (prev_stall) begin
          chk("hold_write", 64'(avl_write), 64'(1));
          chk("hold_addr", 64'(avl_address), 64'(prev_addr));
          chk("hold_data", 64'(avl_writedata), 64'(prev_data));
          chk("hold_bb", 64'(avl_burstbegin), 64'(prev_bb));
        end
        if (avl_write) write_cycles++;
        if (avl_write && avl_waitrequest_n) begin
          chk("sb_nonempty", 64'(sbq.size() != 0), 64'(1));
          if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("beat_addr", 64'(avl_address), 64'(e.addr));
            chk("beat_data", 64'(avl_writedata), 64'(e.data));
            chk("beat_bb", 64'(avl_burstbegin), 64'(e.bb));
          end
          if (beat_n < NB) cap[beat_n] = avl_writedata;
          if (avl_burstbegin) bursts++;
          beat_n++;
        end
        prev_stall = avl_write && !avl_waitrequest_n;
        prev_addr  = avl_address;
        prev_data  = avl_writedata;
        prev_bb    = avl_burstbegin;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic do_start(input logic [2:0] m, input logic [23:0] a, input logic [23:0] b,
                          input bit accepted);
    @(posedge iCLK);
    #1;
    if (accepted) begin
      push_frame(m, a, b);
      beat_n = 0;
      bursts = 0;
      write_cycles = 0;
    end
    iMODE = m;
    iCOLOR_A = a;
    iCOLOR_B = b;
    iSTART = 1'b1;
    @(posedge iCLK);
    #1;
    iSTART = 1'b0;
    if (accepted) begin
      @(negedge iCLK);
      chk("load_busy", 64'(oBUSY), 64'(1));
      chk("load_write", 64'(avl_write), 64'(0));
      chk("load_done", 64'(oDONE), 64'(0));
      @(negedge iCLK);
      chk("first_write", 64'(avl_write), 64'(1));
      chk("first_bb", 64'(avl_burstbegin), 64'(1));
      chk("first_addr", 64'(avl_address), 64'(BASE));
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && !oDONE; i++) @(negedge iCLK);
    chk("done_seen", 64'(oDONE), 64'(1));
    chk("busy_after", 64'(oBUSY), 64'(0));
    chk("write_after", 64'(avl_write), 64'(0));
    chk("addr_after", 64'(avl_address), 64'(BASE));
    chk("beat_count", 64'(beat_n), 64'(NB));
    chk("sb_empty", 64'(sbq.size()), 64'(0));
  endtask

  initial begin
    vecs[0] = '{3'd0, 24'hFF0000, 24'h000000, 1'b0, 32'h00FF0000, 32'h00FF0000};
    vecs[1] = '{3'd1, 24'h00FF00, 24'h0000FF, 1'b1, 32'h0000FF00, 32'h000000FF};
    vecs[2] = '{3'd4, 24'h123456, 24'h654321, 1'b0, 32'h00050505, 32'h000C0C0C};
    vecs[3] = '{3'd2, 24'h111111, 24'h222222, 1'b1, 32'h00111111, 32'h00222222};
    vecs[4] = '{3'd3, 24'hAAAAAA, 24'h555555, 1'b1, 32'h00AAAAAA, 32'h00AAAAAA};
    vecs[5] = '{3'd6, 24'h13579B, 24'h0ABCDE, 1'b0, 32'h000ABCDE, 32'h000ABCDE};

    iRST_n = 1'b0;
    iSTART = 1'b0;
    iMODE = '0;
    iCOLOR_A = '0;
    iCOLOR_B = '0;
    local_init_done = 1'b0;
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    chk("rst_write", 64'(avl_write), 64'(0));
    chk("rst_bb", 64'(avl_burstbegin), 64'(0));
    chk("rst_addr", 64'(avl_address), 64'(BASE));
    chk("rst_data", 64'(avl_writedata), 64'(0));
    chk("rst_busy", 64'(oBUSY), 64'(0));
    chk("rst_done", 64'(oDONE), 64'(0));
    chk("burstcount", 64'(avl_burstcount), 64'(BL));
    @(posedge iCLK);
    #1;
    iRST_n = 1'b1;

    // Start before DDR calibration: must be ignored.
    do_start(3'd0, 24'hFF0000, 24'h0, 1'b0);
    repeat (8) @(negedge iCLK);
    chk("nocal_writes", 64'(write_cycles), 64'(0));
    chk("nocal_busy", 64'(oBUSY), 64'(0));
    chk("nocal_done", 64'(oDONE), 64'(0));
    local_init_done = 1'b1;

    // Table-driven frames; each start after the first comes from DONE.
    for (int i = 0; i < 6; i++) begin
      rand_wait = vecs[i].rnd;
      do_start(vecs[i].mode, vecs[i].a, vecs[i].b, 1'b1);
      wait_done();
      chk("burst_count", 64'(bursts), 64'(NB / BL));
      chk("pix_x5_y0", 64'(cap[5]), 64'(vecs[i].p5));
      chk("pix_x12_y3", 64'(cap[60]), 64'(vecs[i].p60));
      if (!vecs[i].rnd) chk("zero_wait_cycles", 64'(write_cycles), 64'(NB));
      repeat (2) @(negedge iCLK);
    end

    // Start pulsed mid-frame is ignored.
    rand_wait = 1'b1;
    do_start(3'd1, 24'h00FF00, 24'h0000FF, 1'b1);
    for (int i = 0; i < 1000 && beat_n < 20; i++) @(negedge iCLK);
    chk("mid_reached", 64'(beat_n >= 20), 64'(1));
    @(posedge iCLK);
    #1;
    iMODE = 3'd6;
    iCOLOR_B = 24'h010203;
    iSTART = 1'b1;
    @(posedge iCLK);
    #1;
    iSTART = 1'b0;
    wait_done();
    chk("mid_bursts", 64'(bursts), 64'(NB / BL));

    // Reset during burst 7 drops the request; a later start rewrites from base.
    rand_wait = 1'b0;
    repeat (2) @(negedge iCLK);
    do_start(3'd0, 24'hFF0000, 24'h000000, 1'b1);
    for (int i = 0; i < 1000 && beat_n < 29; i++) @(negedge iCLK);
    chk("burst7_reached", 64'(beat_n >= 29 && beat_n < 32), 64'(1));
    iRST_n = 1'b0;
    @(posedge iCLK);
    #1;
    chk("midrst_write", 64'(avl_write), 64'(0));
    chk("midrst_addr", 64'(avl_address), 64'(BASE));
    chk("midrst_busy", 64'(oBUSY), 64'(0));
    chk("midrst_done", 64'(oDONE), 64'(0));
    iRST_n = 1'b1;
    sbq.delete();
    repeat (2) @(negedge iCLK);
    do_start(3'd0, 24'hFF0000, 24'h000000, 1'b1);
    wait_done();
    chk("rewrite_bursts", 64'(bursts), 64'(NB / BL));
    chk("rewrite_pix0", 64'(cap[0]), 64'(32'h00FF0000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
